// File: rtl/ycr_dmi_pkg.sv
// ----------------------------------------------------------------------------
// ycr_dmi_pkg
// Shared constants for the SysCLK-side DMI scan responder.
//   - DMI op field encodings (request and status views)
//   - FSM state enumeration
//   - DTMCS field bit positions, version and idle hint
//   - dtmcs_word(): assembles the DTMCS capture value
// ----------------------------------------------------------------------------
package ycr_dmi_pkg;

    // op field as written by the debugger
    localparam logic [1:0] DMI_OP_NOP     = 2'd0;
    localparam logic [1:0] DMI_OP_READ    = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE   = 2'd2;

    // op field as returned on capture (also the sticky status)
    localparam logic [1:0] DMI_ST_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_ST_FAILED  = 2'd2;
    localparam logic [1:0] DMI_ST_BUSY    = 2'd3;

    typedef enum logic [0:0] {
        DMI_FSM_IDLE = 1'b0,
        DMI_FSM_REQ  = 1'b1
    } dmi_fsm_e;

    // DTMCS layout
    localparam int unsigned DTMCS_LEN              = 32;
    localparam int unsigned DTMCS_VERSION_LSB      = 0;
    localparam int unsigned DTMCS_ABITS_LSB        = 4;
    localparam int unsigned DTMCS_DMISTAT_LSB      = 10;
    localparam int unsigned DTMCS_IDLE_LSB         = 12;
    localparam int unsigned DTMCS_DMIRESET_BIT     = 16;
    localparam int unsigned DTMCS_DMIHARDRESET_BIT = 17;

    localparam logic [3:0] DTMCS_VERSION = 4'd1;
    localparam logic [2:0] DTMCS_IDLE    = 3'd1;

    // dmireset/dmihardreset always read back as 0
    function automatic logic [31:0] dtmcs_word(input logic [1:0] dmistat,
                                               input logic [5:0] abits);
        logic [31:0] w;
        w = '0;
        w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
        w[DTMCS_ABITS_LSB   +: 6] = abits;
        w[DTMCS_DMISTAT_LSB +: 2] = dmistat;
        w[DTMCS_IDLE_LSB    +: 3] = DTMCS_IDLE;
        return w;
    endfunction

endpackage

// File: rtl/ycr_dmi_scan_responder_shreg.sv
// ----------------------------------------------------------------------------
// ycr_dmi_shreg
// Variable-length scan shift register with parallel capture and a registered
// TDO bit.
//   clk, rst_n    : clock, async active-low reset
//   capture_i     : load cap_data_i (wins over shift_i)
//   shift_i       : shift right one bit, tdi_i enters the active-length MSB
//   long_i        : 1 = full SR_W length (DMI), 0 = DTMCS_LEN (DTMCS)
//   tdi_i         : serial input
//   cap_data_i    : parallel capture value
//   shreg_o       : current register contents
//   tdo_o         : bit 0 of the pre-shift value, updated on shift only
// ----------------------------------------------------------------------------
module ycr_dmi_shreg
    import ycr_dmi_pkg::*;
#(
    parameter int unsigned SR_W = 41
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture_i,
    input  logic            shift_i,
    input  logic            long_i,
    input  logic            tdi_i,
    input  logic [SR_W-1:0] cap_data_i,
    output logic [SR_W-1:0] shreg_o,
    output logic            tdo_o
);

    logic [SR_W-1:0] shreg_q, shreg_d;
    logic            tdo_q, tdo_d;

    always_comb begin
        shreg_d = shreg_q;
        tdo_d   = tdo_q;
        if (capture_i) begin
            shreg_d = cap_data_i;
        end else if (shift_i) begin
            shreg_d = shreg_q >> 1;
            // Bits above the DTMCS length simply drift down in short mode;
            // the DTMCS MSB slot is overwritten so they never reach TDO.
            if (long_i) begin
                shreg_d[SR_W-1] = tdi_i;
            end else begin
                shreg_d[DTMCS_LEN-1] = tdi_i;
            end
            tdo_d = shreg_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            tdo_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            tdo_q   <= tdo_d;
        end
    end

    assign shreg_o = shreg_q;
    assign tdo_o   = tdo_q;

endmodule

// File: rtl/ycr_dmi_scan_responder.sv
// ----------------------------------------------------------------------------
// ycr_dmi_scan_responder
// SysCLK-domain end of the DMI scan chain. Decodes the synchronized TAP
// strobes, implements DTMCS and DMI_ACCESS, and runs the req/resp handshake
// toward the Debug Module with busy / sticky-error semantics.
//
// Optional build macro: YCR_DBG_DMI_TIMEOUT_EN
//   When defined, a request that sees no dmi_resp_i within TIMEOUT clk cycles
//   is abandoned and the sticky status becomes FAILED.
//
// Ports:
//   clk, tapc_trst_n            : clock, async active-low reset
//   ch_sel_i, ch_id_i           : chain select and chain identifier
//   ch_capture/shift/update_i   : one-clk strobes per TCK event
//   ch_tdi_i / ch_tdo_o         : serial data in / registered serial data out
//   dmi_req_o, dmi_wr_o         : request and direction to the DM
//   dmi_addr_o, dmi_wdata_o     : request address and write data
//   dmi_resp_i, dmi_rdata_i     : response strobe and read data from the DM
//   dmi_busy_o                  : transaction outstanding
// ----------------------------------------------------------------------------
module ycr_dmi_scan_responder
    import ycr_dmi_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CH_ID_W  = 2,
    parameter int unsigned DTMCS_ID = 1,
    parameter int unsigned DMI_ID   = 2,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               tapc_trst_n,
    input  logic               ch_sel_i,
    input  logic [CH_ID_W-1:0] ch_id_i,
    input  logic               ch_capture_i,
    input  logic               ch_shift_i,
    input  logic               ch_update_i,
    input  logic               ch_tdi_i,
    output logic               ch_tdo_o,
    output logic               dmi_req_o,
    output logic               dmi_wr_o,
    output logic [ADDR_W-1:0]  dmi_addr_o,
    output logic [DATA_W-1:0]  dmi_wdata_o,
    input  logic               dmi_resp_i,
    input  logic [DATA_W-1:0]  dmi_rdata_i,
    output logic               dmi_busy_o
);

    localparam int unsigned SR_W = ADDR_W + DATA_W + 2;

    localparam logic [0:0] ST_IDLE = DMI_FSM_IDLE;
    localparam logic [0:0] ST_REQ  = DMI_FSM_REQ;

    logic [0:0]        state_q,  state_d;
    logic [1:0]        sticky_q, sticky_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              wr_q,     wr_d;

    logic              sel_dtmcs, sel_dmi;
    logic              cap_stb, shift_stb, upd_stb;
    logic              busy;
    logic [1:0]        cap_op;
    logic [SR_W-1:0]   cap_data;
    logic [SR_W-1:0]   shreg;
    logic [1:0]        upd_op;
    logic [DATA_W-1:0] upd_data;
    logic [ADDR_W-1:0] upd_addr;

    // Strobe qualification and update > capture > shift priority
    assign sel_dtmcs = ch_sel_i && (ch_id_i == CH_ID_W'(DTMCS_ID));
    assign sel_dmi   = ch_sel_i && (ch_id_i == CH_ID_W'(DMI_ID));

    assign upd_stb   = (sel_dtmcs || sel_dmi) && ch_update_i;
    assign cap_stb   = (sel_dtmcs || sel_dmi) && ch_capture_i && !ch_update_i;
    assign shift_stb = (sel_dtmcs || sel_dmi) && ch_shift_i && !ch_update_i
                       && !ch_capture_i;

    assign busy   = (state_q == ST_REQ);
    assign cap_op = busy ? DMI_ST_BUSY : sticky_q;

    always_comb begin
        if (sel_dmi) begin
            cap_data = {addr_q, rdata_q, cap_op};
        end else begin
            cap_data = SR_W'(dtmcs_word(sticky_q, 6'(ADDR_W)));
        end
    end

    ycr_dmi_shreg #(
        .SR_W       (SR_W)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (tapc_trst_n),
        .capture_i  (cap_stb),
        .shift_i    (shift_stb),
        .long_i     (sel_dmi),
        .tdi_i      (ch_tdi_i),
        .cap_data_i (cap_data),
        .shreg_o    (shreg),
        .tdo_o      (ch_tdo_o)
    );

    assign upd_op   = shreg[1:0];
    assign upd_data = shreg[DATA_W+1:2];
    assign upd_addr = shreg[SR_W-1:DATA_W+2];

`ifdef YCR_DBG_DMI_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_tc;

    // Down-counter loaded on REQ entry; terminal count ends the request
    assign cnt_tc = (cnt_q == '0);
`endif

    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
`ifdef YCR_DBG_DMI_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        // Outstanding transaction; a response in IDLE falls through unused
        if (busy) begin
            if (dmi_resp_i) begin
                state_d = ST_IDLE;
                if (!wr_q) begin
                    rdata_d = dmi_rdata_i;
                end
`ifdef YCR_DBG_DMI_TIMEOUT_EN
            end else if (cnt_tc) begin
                state_d  = ST_IDLE;
                sticky_d = DMI_ST_FAILED;
            end else begin
                cnt_d = cnt_q - 1'b1;
`endif
            end
        end

        // A DMI capture that observes busy leaves the error sticky
        if (cap_stb && sel_dmi && busy) begin
            sticky_d = DMI_ST_BUSY;
        end

        if (upd_stb && sel_dmi) begin
            if (busy) begin
                sticky_d = DMI_ST_BUSY;
            end else if ((sticky_q == DMI_ST_SUCCESS) &&
                         ((upd_op == DMI_OP_READ) || (upd_op == DMI_OP_WRITE))) begin
                state_d = ST_REQ;
                addr_d  = upd_addr;
                wdata_d = upd_data;
                wr_d    = (upd_op == DMI_OP_WRITE);
`ifdef YCR_DBG_DMI_TIMEOUT_EN
                cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
            end
        end

        // Hard reset abandons any request; a late response then hits IDLE
        if (upd_stb && sel_dtmcs) begin
            if (shreg[DTMCS_DMIRESET_BIT]) begin
                sticky_d = DMI_ST_SUCCESS;
            end
            if (shreg[DTMCS_DMIHARDRESET_BIT]) begin
                sticky_d = DMI_ST_SUCCESS;
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            state_q  <= ST_IDLE;
            sticky_q <= DMI_ST_SUCCESS;
            addr_q   <= '0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

`ifdef YCR_DBG_DMI_TIMEOUT_EN
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Request outputs are the registered transaction state
    assign dmi_req_o   = busy;
    assign dmi_busy_o  = busy;
    assign dmi_wr_o    = wr_q;
    assign dmi_addr_o  = addr_q;
    assign dmi_wdata_o = wdata_q;

endmodule

// File: tb/tb_ycr_dmi_scan_responder.sv
module tb_ycr_dmi_scan_responder;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int CH_ID_W = 2;
    localparam int SR_W    = ADDR_W + DATA_W + 2;
    localparam int TIMEOUT = 1023;

    logic               clk = 1'b0;
    logic               tapc_trst_n;
    logic               ch_sel_i;
    logic [CH_ID_W-1:0] ch_id_i;
    logic               ch_capture_i, ch_shift_i, ch_update_i, ch_tdi_i;
    logic               ch_tdo_o;
    logic               dmi_req_o, dmi_wr_o, dmi_busy_o;
    logic [ADDR_W-1:0]  dmi_addr_o;
    logic [DATA_W-1:0]  dmi_wdata_o;
    logic               dmi_resp_i;
    logic [DATA_W-1:0]  dmi_rdata_i;

    always #5 clk = ~clk;

    ycr_dmi_scan_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_ID_W(CH_ID_W),
        .DTMCS_ID(1), .DMI_ID(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .tapc_trst_n(tapc_trst_n),
        .ch_sel_i(ch_sel_i), .ch_id_i(ch_id_i),
        .ch_capture_i(ch_capture_i), .ch_shift_i(ch_shift_i),
        .ch_update_i(ch_update_i), .ch_tdi_i(ch_tdi_i), .ch_tdo_o(ch_tdo_o),
        .dmi_req_o(dmi_req_o), .dmi_wr_o(dmi_wr_o), .dmi_addr_o(dmi_addr_o),
        .dmi_wdata_o(dmi_wdata_o), .dmi_resp_i(dmi_resp_i),
        .dmi_rdata_i(dmi_rdata_i), .dmi_busy_o(dmi_busy_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural state of the debug transport
    logic [1:0]        m_sticky;
    logic              m_busy, m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_rdata, m_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dtmcs_exp(input logic [1:0] stat);
        return 32'((1 << 12) + (int'(stat) << 10) + (ADDR_W << 4) + 1);
    endfunction

    task automatic do_capture(input logic [1:0] id);
        ch_sel_i = 1'b1; ch_id_i = id; ch_capture_i = 1'b1;
        tick();
        ch_capture_i = 1'b0;
    endtask

    task automatic do_update(input logic [1:0] id);
        ch_sel_i = 1'b1; ch_id_i = id; ch_update_i = 1'b1;
        tick();
        ch_update_i = 1'b0;
    endtask

    task automatic do_shift(input logic [SR_W-1:0] din, input int n, output logic [SR_W-1:0] dout);
        dout = '0;
        ch_shift_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            ch_tdi_i = din[i];
            tick();
            dout[i] = ch_tdo_o;
        end
        ch_shift_i = 1'b0;
        ch_tdi_i   = 1'b0;
    endtask

    task automatic dmi_scan(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [1:0] op, input string tag);
        logic [SR_W-1:0] exp_s, got;
        do_capture(2'd2);
        exp_s = {m_addr, m_rdata, (m_busy ? 2'd3 : m_sticky)};
        if (m_busy) m_sticky = 2'd3;
        do_shift({addr, data, op}, SR_W, got);
        chk({tag, "_cap"}, 64'(got), 64'(exp_s));
        do_update(2'd2);
        if (m_busy) begin
            m_sticky = 2'd3;
        end else if (m_sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
            m_busy = 1'b1; m_addr = addr; m_wdata = data; m_wr = (op == 2'd2);
        end
        chk({tag, "_req"}, 64'(dmi_req_o), 64'(m_busy));
        chk({tag, "_busy"}, 64'(dmi_busy_o), 64'(m_busy));
        if (m_busy) begin
            chk({tag, "_addr"}, 64'(dmi_addr_o), 64'(m_addr));
            chk({tag, "_wr"}, 64'(dmi_wr_o), 64'(m_wr));
            if (m_wr) chk({tag, "_wdata"}, 64'(dmi_wdata_o), 64'(m_wdata));
        end
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, input string tag);
        logic [SR_W-1:0] got;
        logic [31:0]     exp_w;
        do_capture(2'd1);
        exp_w = dtmcs_exp(m_sticky);
        do_shift(SR_W'(din), 32, got);
        chk({tag, "_cap"}, 64'(got[31:0]), 64'(exp_w));
        do_update(2'd1);
        if (din[16]) m_sticky = 2'd0;
        if (din[17]) begin m_sticky = 2'd0; m_busy = 1'b0; end
        chk({tag, "_req"}, 64'(dmi_req_o), 64'(m_busy));
    endtask

    task automatic dm_respond(input logic [DATA_W-1:0] rd, input int delay, input string tag);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, "_hold"}, 64'(dmi_req_o), 64'(m_busy));
        end
        dmi_resp_i = 1'b1; dmi_rdata_i = rd;
        tick();
        dmi_resp_i = 1'b0; dmi_rdata_i = $urandom;
        if (m_busy) begin
            if (!m_wr) m_rdata = rd;
            m_busy = 1'b0;
        end
        chk({tag, "_drop"}, 64'(dmi_req_o), 64'(m_busy));
        chk({tag, "_nbusy"}, 64'(dmi_busy_o), 64'(m_busy));
    endtask

    initial begin
        logic [SR_W-1:0] got;
        logic [1:0]      op;

        tapc_trst_n = 1'b0;
        ch_sel_i = 1'b0; ch_id_i = '0; ch_capture_i = 1'b0; ch_shift_i = 1'b0;
        ch_update_i = 1'b0; ch_tdi_i = 1'b0; dmi_resp_i = 1'b0; dmi_rdata_i = '0;
        m_sticky = '0; m_busy = 1'b0; m_wr = 1'b0; m_addr = '0; m_rdata = '0; m_wdata = '0;
        repeat (3) tick();
        chk("rst_req", 64'(dmi_req_o), 0);
        chk("rst_busy", 64'(dmi_busy_o), 0);
        chk("rst_tdo", 64'(ch_tdo_o), 0);
        chk("rst_wr", 64'(dmi_wr_o), 0);
        chk("rst_addr", 64'(dmi_addr_o), 0);
        chk("rst_wdata", 64'(dmi_wdata_o), 0);
        tapc_trst_n = 1'b1;
        tick();

        // DTMCS readout
        dtmcs_scan(32'h0, "dtmcs_id");

        // Strobes on unselected chains leave TDO alone; capture beats shift
        do_capture(2'd1);
        do_shift('0, 1, got);
        chk("tdo_bit0", 64'(ch_tdo_o), 1);
        ch_sel_i = 1'b0; ch_shift_i = 1'b1; tick(); ch_shift_i = 1'b0;
        chk("ign_nosel", 64'(ch_tdo_o), 1);
        ch_sel_i = 1'b1; ch_id_i = 2'd0; ch_shift_i = 1'b1; tick(); ch_shift_i = 1'b0;
        chk("ign_id0", 64'(ch_tdo_o), 1);
        ch_id_i = 2'd3; ch_shift_i = 1'b1; tick(); ch_shift_i = 1'b0;
        chk("ign_id3", 64'(ch_tdo_o), 1);
        ch_id_i = 2'd1; ch_capture_i = 1'b1; ch_shift_i = 1'b1; tick();
        ch_capture_i = 1'b0; ch_shift_i = 1'b0;
        chk("prio_cap", 64'(ch_tdo_o), 1);
        do_shift('0, 2, got);
        chk("prio_reload", 64'(got[1:0]), 64'(2'b01));

        // Write, then read with the returned data scanned back out
        dmi_scan(7'h10, 32'hDEADBEEF, 2'd2, "wr");
        dm_respond($urandom, 3, "wr_resp");
        dmi_scan(7'h11, $urandom, 2'd1, "rd");
        chk("rd_wr", 64'(dmi_wr_o), 0);
        dm_respond(32'h12345678, 2, "rd_resp");
        dmi_scan(7'h00, 32'h0, 2'd0, "rd_back");

        // Busy: capture during REQ sets the sticky error until dmireset
        dmi_scan(7'h22, $urandom, 2'd1, "bz_start");
        dmi_scan(7'h33, $urandom, 2'd2, "bz_cap");
        dm_respond($urandom, 1, "bz_resp");
        dmi_scan(7'h44, $urandom, 2'd1, "bz_sticky");
        dtmcs_scan(32'h0, "bz_stat");
        dtmcs_scan(32'h0001_0000, "dmireset");
        dmi_scan(7'h00, 32'h0, 2'd0, "bz_clear");

        // Hard reset drops the request; the late response is ignored
        dmi_scan(7'h55, $urandom, 2'd1, "hr_start");
        dtmcs_scan(32'h0002_0000, "hardreset");
        dm_respond(32'hCAFEF00D, 0, "hr_late");
        dmi_scan(7'h00, 32'h0, 2'd0, "hr_after");

        // Randomized traffic, including nops and responses while idle
        for (int k = 0; k < 12; k++) begin
            op = 2'($urandom_range(0, 3));
            dmi_scan(7'($urandom), $urandom, op, "rnd");
            dm_respond($urandom, int'($urandom_range(0, 4)), "rnd_resp");
        end
        dmi_scan(7'h00, 32'h0, 2'd0, "rnd_final");

`ifdef YCR_DBG_DMI_TIMEOUT_EN
        begin
            int k;
            dmi_scan(7'h01, $urandom, 2'd1, "to_start");
            for (k = 0; k < TIMEOUT + 10 && dmi_req_o; k++) tick();
            chk("to_drop", 64'(dmi_req_o), 0);
            m_busy = 1'b0; m_sticky = 2'd2;
            dmi_scan(7'h00, 32'h0, 2'd0, "to_cap");
            dtmcs_scan(32'h0001_0000, "to_clear");
        end
`endif

        // Asynchronous reset in the middle of a request
        dmi_scan(7'h7F, $urandom, 2'd2, "rst_start");
        do_capture(2'd1);
        do_shift('0, 1, got);
        chk("rst_tdo_pre", 64'(ch_tdo_o), 1);
        #2 tapc_trst_n = 1'b0;
        #1;
        chk("arst_req", 64'(dmi_req_o), 0);
        chk("arst_busy", 64'(dmi_busy_o), 0);
        chk("arst_tdo", 64'(ch_tdo_o), 0);
        tick();
        tapc_trst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
